// File: rtl/reg_reader.sv
// reg_reader: read-side port for a bank of one-bit registers.
//
// On acceptance of a request, the reader takes a snapshot of the bank outputs.
// It then streams the selected bits one per beat over a valid/ready handshake.
// The bank is never written.
//
// Handshake rules:
//   - A transfer happens on a rising edge where valid && ready.
//   - While valid is high and ready is low, every payload signal holds
//     stable.
//   - No valid depends combinationally on the matching ready.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   reset      in   synchronous active-high reset
//   reg_bits   in   live bank outputs, bit i = register i
//   req_valid  in   read request present
//   req_ready  out  reader can accept a request (high exactly in IDLE)
//   req_addr   in   first register to read
//   req_burst  in   0 = single register, 1 = req_addr..N_REGS-1
//   rd_valid   out  beat valid
//   rd_ready   in   consumer accepts the beat
//   rd_data    out  register bit (0 on an erroring request)
//   rd_addr    out  address of the bit on rd_data
//   rd_last    out  final beat of the request
//   rd_err     out  request address was >= N_REGS
//   busy       out  request in progress; this is also the FSM state
module reg_reader #(
    parameter int N_REGS = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_REGS-1:0] reg_bits,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_burst,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last,
    output logic              rd_err,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_REGS - 1);
    // One extra bit so that N_REGS == 2^ADDR_W is representable.
    localparam logic [ADDR_W:0]   N_REGS_W  = (ADDR_W + 1)'(N_REGS);

    state_t              state_q, state_d;
    logic [N_REGS-1:0]   snap_q, snap_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic                mode_q, mode_d;
    logic                err_q, err_d;

    logic                addr_oor;
    logic                last_beat;
    logic                sel_bit;

    assign addr_oor  = ({1'b0, req_addr} >= N_REGS_W);
    assign last_beat = err_q || !mode_q || (cur_q == LAST_ADDR);

    // Explicit compare mux: cur_q may exceed N_REGS-1 on an erroring request,
    // so the snapshot is never indexed directly with it.
    always_comb begin
        sel_bit = 1'b0;
        for (int i = 0; i < N_REGS; i++) begin
            if (cur_q == ADDR_W'(i)) begin
                sel_bit = snap_q[i];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            snap_q  <= '0;
            cur_q   <= '0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cur_q   <= cur_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cur_d   = cur_q;
        mode_d  = mode_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    snap_d  = reg_bits;
                    cur_d   = req_addr;
                    mode_d  = req_burst;
                    err_d   = addr_oor;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (rd_ready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        cur_d = cur_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: depends on registered state only.
    always_comb begin
        req_ready = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = 1'b0;
        rd_addr   = '0;
        rd_last   = 1'b0;
        rd_err    = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
            end
            SEND: begin
                busy     = 1'b1;
                rd_valid = 1'b1;
                rd_addr  = cur_q;
                rd_data  = err_q ? 1'b0 : sel_bit;
                rd_last  = last_beat;
                rd_err   = err_q;
            end
            default: req_ready = 1'b1;
        endcase
    end

endmodule
